// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces active-low keys, emitting one-cycle press pulses.
// Define KEY_AUTOREPEAT_EN to add per-key hold-to-repeat pulses on key_press.
module key_debounce #(
  parameter int N_KEYS     = 2,
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_db,
  output logic [N_KEYS-1:0] key_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_params
    $error("key_debounce: cycle parameters must be at least 1");
  end
  logic [N_KEYS-1:0] s1, sync, acc, db_n, press_ev, rep;
  logic [CW-1:0]     cnt [N_KEYS];
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_KEYS; i++) acc[i] = sync[i] != key_db[i] && cnt[i] == DEB_LAST;
    db_n     = (acc & sync) | (~acc & key_db);
    press_ev = acc & ~sync;
  end
  // cnt is cleared on acceptance, so it never passes DEB_CYCLES-1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1        <= '1;
      sync      <= '1;
      key_db    <= '1;
      key_press <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      s1        <= key_in;
      sync      <= s1;
      key_db    <= db_n;
      key_press <= press_ev | rep;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= (sync[i] == key_db[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
    end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REP_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
  rep_state_t      st   [N_KEYS];
  logic [RW-1:0]   rcnt [N_KEYS];
  // a release accepted this cycle wins over a coinciding repeat
  always_comb begin
    rep = '0;
    for (int i = 0; i < N_KEYS; i++)
      rep[i] = !db_n[i] && st[i] != IDLE && rcnt[i] == (st[i] == DELAY ? RD_LAST : RP_LAST);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        st[i]   <= IDLE;
        rcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++)
        if (db_n[i]) begin
          st[i]   <= IDLE;
          rcnt[i] <= '0;
        end else if (st[i] == IDLE) begin
          if (press_ev[i]) st[i] <= DELAY;
          rcnt[i] <= '0;
        end else if (rep[i]) begin
          st[i]   <= REPEAT;
          rcnt[i] <= '0;
        end else rcnt[i] <= rcnt[i] + 1'b1;
    end
`else
  assign rep = '0;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce against a sample-window reference model.
module tb_key_debounce;
  localparam int N = 2, DEB = 8, RD = 20, RP = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] key_in, key_db, key_press;
  int n_tests = 0, n_fail = 0;
  key_debounce #(.N_KEYS(N), .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_db(key_db), .key_press(key_press)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Reference: a key is accepted when its last DEB synchronised samples all differ from the level;
  // repeats follow from the press edge number by arithmetic.
  logic [N-1:0] hist [DEB+2];
  logic [N-1:0] m_db, m_press;
  int edge_n;
  int p_edge [N];
  always @(posedge clk or posedge rst) begin : ref_model
    logic [N-1:0] h [DEB+2];
    logic [N-1:0] db, pr;
    int pe [N];
    bit win;
    int d;
    if (rst) begin
      for (int j = 0; j < DEB + 2; j++) hist[j] <= '1;
      m_db <= '1;
      m_press <= '0;
      edge_n <= 0;
    end else begin
      h[0] = key_in;
      for (int j = 1; j < DEB + 2; j++) h[j] = hist[j-1];
      db = m_db;
      pr = '0;
      pe = p_edge;
      for (int k = 0; k < N; k++) begin
        win = 1'b1;
        for (int j = 2; j < DEB + 2; j++) if (h[j][k] == db[k]) win = 1'b0;
        if (win) begin
          db[k] = ~db[k];
          if (!db[k]) begin
            pr[k] = 1'b1;
            pe[k] = edge_n + 1;
          end
        end else if (AUTO && !db[k]) begin
          d = edge_n + 1 - pe[k];
          pr[k] = d == RD || (d > RD && (d - RD) % RP == 0);
        end
      end
      hist <= h;
      m_db <= db;
      m_press <= pr;
      edge_n <= edge_n + 1;
      p_edge <= pe;
    end
  end
  always @(negedge clk) begin
    check("db", key_db, m_db);
    check("press", key_press, m_press);
  end
  initial begin
    int cnt_got, cnt_exp, first, pos_err, late, np, at, extra;
    int hold [N];
    logic [N-1:0] lo, pr;
    logic exp_p;
    rst = 1'b1;
    key_in = 2'b00;
    step(3);
    check("reset_db", key_db, 2'b11);
    check("reset_press", key_press, 2'b00);
    key_in = 2'b11;
    step(1);
    rst = 1'b0;
    step(12);
    // clean press then long hold
    key_in = 2'b10;
    cnt_got = 0; cnt_exp = 0; first = 0; pos_err = 0;
    for (int e = 1; e <= 200; e++) begin
      step(1);
      if (e == 9) check("press_db9", key_db, 2'b11);
      if (e == 10) begin
        check("press_db10", key_db, 2'b10);
        check("press_p10", key_press, 2'b01);
      end
      if (e == 11) check("press_p11", key_press, 2'b00);
      exp_p = e == 10 || (AUTO && e >= 30 && (e - 30) % 5 == 0);
      if (key_press[0]) begin
        cnt_got++;
        if (first == 0) first = e;
      end
      if (exp_p) cnt_exp++;
      if (key_press[0] != exp_p) pos_err++;
    end
    check("hold_first", first, 10);
    check("hold_count", cnt_got, cnt_exp);
    check("hold_timing", pos_err, 0);
    // release lands on a would-be repeat cycle when repeating
    key_in = 2'b11;
    late = 0;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (e == 9) check("rel_db9", key_db, 2'b10);
      if (e == 10) check("rel_db10", key_db, 2'b11);
      if (e >= 10 && key_press != 2'b00) late++;
    end
    check("rel_no_pulse", late, 0);
    // bounce: toggles every 3 cycles, final fall at c=30
    np = 0; at = -1;
    for (int c = 0; c < 50; c++) begin
      if (c <= 30 && c % 3 == 0) key_in[0] = ((c / 3) % 2) != 0;
      step(1);
      if (key_press[0]) begin
        np++;
        at = c;
      end
    end
    check("bounce_count", np, 1);
    check("bounce_at", at, 39);
    key_in = 2'b11;
    step(15);
    // glitch of 7 cycles on key 1
    lo = '0; pr = '0;
    for (int c = 0; c < 20; c++) begin
      key_in[1] = c >= 7;
      step(1);
      lo |= ~key_db;
      pr |= key_press;
    end
    check("glitch_db", lo, 2'b00);
    check("glitch_press", pr, 2'b00);
    // both keys together
    key_in = 2'b00;
    extra = 0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (e == 10) check("both_press", key_press, 2'b11);
      else if (key_press != 2'b00) extra++;
    end
    check("both_single", extra, 0);
    key_in = 2'b11;
    step(15);
    // reset while key 0 is held and repeating
    key_in = 2'b10;
    step(40);
    rst = 1'b1;
    #1;
    check("rst_mid_db", key_db, 2'b11);
    check("rst_mid_press", key_press, 2'b00);
    step(2);
    rst = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      if (e == 9) check("requal_p9", key_press, 2'b00);
      if (e == 10) begin
        check("requal_press", key_press, 2'b01);
        check("requal_db", key_db, 2'b10);
      end
    end
    key_in = 2'b11;
    step(15);
    // randomized holds, checked each cycle by the model
    hold[0] = 0;
    hold[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          key_in[k] = $urandom_range(0, 1) != 0;
          hold[k] = $urandom_range(1, 40);
        end
        hold[k]--;
      end
      step(1);
    end
    key_in = 2'b11;
    step(30);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
